// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the segmented add/subtract sequencer.
package adder_ctrl_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter that must hold 0..nseg inclusive.
   function automatic int cnt_w(input int nseg);
      return $clog2(nseg + 1);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit carry-skip adder: ripple chain of cells plus a bypass mux
// that forwards cin directly when every bit of the group propagates.
module adder_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             grp_p
);

   logic [SLICE:0]   c;
   logic [SLICE-1:0] p;

   assign c[0] = cin;

   for (genvar i = 0; i < SLICE; i++) begin : g_cell
      skip_carry_adder u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1]),
         .p    (p[i])
      );
   end

   assign grp_p = &p;
   // With the whole group propagating, the ripple result equals cin; the mux lets cin bypass the chain.
   assign cout  = grp_p ? cin : c[SLICE];

endmodule

// File: rtl/skip_carry_adder.sv
// One-bit full-adder cell exposing its propagate term for the slice-level carry skip.
module skip_carry_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout,
   output logic p
);

   assign p    = a ^ b;
   assign sum  = p ^ cin;
   assign cout = (a & b) | (p & cin);

endmodule

// File: rtl/adder_seq_ctrl.sv
// Signed WIDTH-bit add/subtract done one SLICE-bit segment per cycle, LSB first, through a shared slice.
// Result valid NSEG cycles after accept and held in DONE until the consumer takes it; no new operands meanwhile.
module adder_seq_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   input  logic [WIDTH-1:0]                    a_i,
   input  logic [WIDTH-1:0]                    b_i,
   input  logic                                sub_i,
   output logic                                out_valid_o,
   input  logic                                out_ready_i,
   output logic [WIDTH-1:0]                    sum_o,
   output logic                                cout_o,
   output logic                                ovf_o,
   output logic [cnt_w(WIDTH/SLICE)-1:0]       skip_cnt_o,
   output logic                                busy_o
);

   localparam int NSEG = WIDTH / SLICE;
   localparam int CW   = cnt_w(NSEG);
   localparam int SW   = $clog2(NSEG);

   state_t            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  res_q;
   logic              carry_q;
   logic [SW-1:0]     seg_q;
   logic [CW-1:0]     skip_q;

   logic [SLICE-1:0]  seg_a;
   logic [SLICE-1:0]  seg_b;
   logic [SLICE-1:0]  seg_sum;
   logic              seg_cout;
   logic              seg_p;
   logic              last_seg;
   logic              seg_ovf;

   assign seg_a    = a_q[int'(seg_q)*SLICE +: SLICE];
   assign seg_b    = b_q[int'(seg_q)*SLICE +: SLICE];
   assign last_seg = (seg_q == SW'(NSEG - 1));

   // b_q already holds the inverted operand for subtracts, so this is the plain signed-add overflow rule.
   assign seg_ovf  = (seg_a[SLICE-1] == seg_b[SLICE-1]) && (seg_sum[SLICE-1] != seg_a[SLICE-1]);

   adder_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a     (seg_a),
      .b     (seg_b),
      .cin   (carry_q),
      .sum   (seg_sum),
      .cout  (seg_cout),
      .grp_p (seg_p)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         carry_q    <= 1'b0;
         seg_q      <= '0;
         skip_q     <= '0;
         sum_o      <= '0;
         cout_o     <= 1'b0;
         ovf_o      <= 1'b0;
         skip_cnt_o <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i ^ {WIDTH{sub_i}};
                  carry_q <= sub_i;
                  seg_q   <= '0;
                  skip_q  <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               res_q[int'(seg_q)*SLICE +: SLICE] <= seg_sum;
               carry_q <= seg_cout;
               skip_q  <= skip_q + CW'(seg_p);
               seg_q   <= seg_q + 1'b1;
               // Visible outputs update only at completion so they stay put until the next result.
               if (last_seg) begin
                  sum_o      <= {seg_sum, res_q[WIDTH-SLICE-1:0]};
                  cout_o     <= seg_cout;
                  ovf_o      <= seg_ovf;
                  skip_cnt_o <= skip_q + CW'(seg_p);
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl at default parameters with hand-computed expectations.
module tb_adder_seq_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        sub_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [31:0] sum_o;
   logic        cout_o;
   logic        ovf_o;
   logic [2:0]  skip_cnt_o;
   logic        busy_o;

   int vectors = 0;
   int miscompares = 0;

   adder_seq_ctrl dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .sub_i       (sub_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .sum_o       (sum_o),
      .cout_o      (cout_o),
      .ovf_o       (ovf_o),
      .skip_cnt_o  (skip_cnt_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int n = 0;
      while (!in_ready_o && n < 30) begin
         tick();
         n++;
      end
      check("issue_ready", in_ready_o, 1);
      a_i = a;
      b_i = b;
      sub_i = sub;
      in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid_o && lat < 30);
   endtask

   task automatic check_result(input string tag, input logic [31:0] es, input logic ec,
                               input logic eo, input logic [2:0] ek);
      check({tag, "_sum"}, sum_o, es);
      check({tag, "_cout"}, cout_o, ec);
      check({tag, "_ovf"}, ovf_o, eo);
      check({tag, "_skip"}, skip_cnt_o, ek);
   endtask

   // Full transaction with out_ready_i high: 4-cycle latency, 1-cycle-wide valid.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] es, input logic ec,
                         input logic eo, input logic [2:0] ek);
      int lat;
      issue(a, b, sub);
      check({tag, "_busy"}, busy_o, 1);
      check({tag, "_rdy_low"}, in_ready_o, 0);
      wait_valid(lat);
      check({tag, "_lat"}, lat, 4);
      check_result(tag, es, ec, eo, ek);
      tick();
      check({tag, "_vld_1cyc"}, out_valid_o, 0);
   endtask

   initial begin
      int lat;

      // Reset state
      #12;
      check("rst_vld", out_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check_result("rst", 32'h0, 0, 0, 3'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      check("rel_rdy", in_ready_o, 1);

      // Basic adds, subtracts and carry/overflow boundaries
      run_op("add5_7", 32'd5, 32'd7, 0, 32'h0000000C, 0, 0, 3'd0);
      run_op("add_maxpos", 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1, 3'd2);
      run_op("sub3_5", 32'd3, 32'd5, 1, 32'hFFFFFFFE, 0, 0, 3'd3);
      run_op("sub_minneg", 32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 1, 1, 3'd2);
      run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0, 3'd3);
      run_op("add_allp", 32'hFFFFFFFF, 32'h00000000, 0, 32'hFFFFFFFF, 0, 0, 3'd4);

      // Backpressure in DONE with new operands waiting
      out_ready_i = 1'b0;
      issue(32'h10, 32'h20, 0);
      wait_valid(lat);
      check("bp_lat", lat, 4);
      a_i = 32'h100;
      b_i = 32'h1;
      sub_i = 1'b1;
      in_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_vld", out_valid_o, 1);
         check("bp_rdy", in_ready_o, 0);
         check("bp_sum", sum_o, 32'h30);
      end
      out_ready_i = 1'b1;
      tick();
      check("bp_idle_vld", out_valid_o, 0);
      check("bp_idle_rdy", in_ready_o, 1);
      tick();
      check("bp_acc_busy", busy_o, 1);
      in_valid_i = 1'b0;
      wait_valid(lat);
      check("bp2_lat", lat, 4);
      check_result("bp2", 32'h000000FF, 1, 0, 3'd2);
      tick();

      // Reset in the middle of RUN
      issue(32'h12345678, 32'h11111111, 0);
      tick();
      tick();
      check("mid_busy", busy_o, 1);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_vld", out_valid_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check_result("mid_rst", 32'h0, 0, 0, 3'd0);
      #5;
      rst_ni = 1'b1;
      tick();
      check("mid_rel_rdy", in_ready_o, 1);
      check("mid_rel_vld", out_valid_o, 0);
      run_op("post_rst", 32'd1, 32'd1, 0, 32'h00000002, 0, 0, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-cycle sequencer that runs a WIDTH-bit signed add/subtract through one shared SLICE-bit carry-skip adder slice, one segment per cycle, LSB segment first. A carry register is held between segments. Operands are accepted and results returned over valid/ready handshakes. The block sits between the operand issue logic and the result consumer, so a full-width adder need not be instantiated.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE
SLICE, 8, bits processed per cycle by the shared slice
NSEG, WIDTH/SLICE, derived localparam (not overridable); must be >= 2

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  operand request valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  signed operand A
b_i  input  WIDTH  signed operand B
sub_i  input  1  1 = compute A-B, 0 = compute A+B
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  result, two's complement
cout_o  output  1  carry out of the MSB (for subtract, 1 = no borrow)
ovf_o  output  1  signed overflow
skip_cnt_o  output  $clog2(NSEG+1)  number of segments whose group-propagate was all ones
busy_o  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_ni=0):
  - State returns to IDLE immediately.
  - in_ready_o=1 after release; out_valid_o=0.
  - sum_o, cout_o, ovf_o, skip_cnt_o, seg counter and carry register all clear to 0.
  - Reset mid-RUN or mid-DONE abandons the operation; no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1, busy_o=0.
  - On in_valid_i&&in_ready_o:
    - latch a_i;
    - latch b_i XOR {WIDTH{sub_i}} as B';
    - carry <= sub_i; seg <= 0; skip_cnt <= 0; go RUN.
- RUN:
  - in_ready_o=0.
  - Each cycle feeds segment seg (bits seg*SLICE +: SLICE) of A and B' plus carry to the slice.
  - Writes the slice sum into the result register at that position.
  - carry <= slice cout.
  - skip_cnt increments when slice group-propagate (&(a^b') over the segment) = 1.
  - seg increments each cycle.
  - On seg==NSEG-1:
    - cout_o <= slice cout;
    - ovf_o <= carry into MSB XOR slice cout, i.e. (A'msb==B'msb)&&(sum msb!=A msb);
    - go DONE.
- Latency: operands accepted at edge k; out_valid_o rises after edge k+NSEG (4 cycles at defaults).
  - Throughput is one op per NSEG+2 cycles minimum.
- DONE:
  - out_valid_o=1; sum_o/cout_o/ovf_o/skip_cnt_o are held stable.
  - in_valid_i is ignored and in_ready_o=0.
  - On out_valid_o&&out_ready_i, go IDLE; outputs keep their last value until the next completion.
- out_ready_i held high on entry to DONE gives a 1-cycle DONE.
- There is no combinational path from any input to in_ready_o or out_valid_o; both are decoded from registered state only.
- Width rules:
  - Slice arithmetic is unsigned SLICE+1 bits.
  - Signedness is applied only in the ovf_o computation.
  - Wrap-around is modulo 2^WIDTH.
- Simultaneous events: in_valid_i asserted in RUN/DONE is held off by the producer until in_ready_o; its operands must stay stable.

Decomposition:
- Package adder_ctrl_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH/SLICE constants;
  - function computing the skip_cnt width.
- Sub-module adder_slice (combinational, SLICE-bit chain of skip_carry_adder cells):
  - ports a, b, cin, sum, cout, and group propagate grp_p;
  - grp_p drives the segment-level carry skip and the skip counter.
- Control FSM, operand/result registers and counters are in adder_seq_ctrl.

Test Plan:
1. Add 5+7 (defaults), out_ready_i=1 -> sum_o=0x0000000C, cout_o=0, ovf_o=0, skip_cnt_o=0, out_valid_o 4 cycles after accept, 1 cycle wide.
2. Add 0x7FFFFFFF+0x00000001 -> sum_o=0x80000000, cout_o=0, ovf_o=1, skip_cnt_o=2.
3. Sub 3-5 -> sum_o=0xFFFFFFFE, cout_o=0, ovf_o=0, skip_cnt_o=3. Then sub 0x80000000-1 -> sum_o=0x7FFFFFFF, cout_o=1, ovf_o=1.
4. Add 0xFFFFFFFF+0x00000001 -> sum_o=0, cout_o=1, ovf_o=0, skip_cnt_o=3. Then add 0xFFFFFFFF+0x00000000 -> skip_cnt_o=4 (all segments propagate).
5. Hold out_ready_i=0 for 10 cycles in DONE while driving in_valid_i=1 with new operands:
   - out_valid_o stays 1 and sum_o is stable;
   - in_ready_o=0 throughout;
   - on out_ready_i=1, IDLE is entered and the pending operands are accepted next cycle and computed correctly.
6. Assert rst_ni=0 mid-RUN (seg=2):
   - out_valid_o=0 and busy_o=0 immediately; all outputs read 0;
   - after release in_ready_o=1, and a following 1+1 yields sum_o=2 with no stale carry.
